// File: rtl/mux_arbiter2_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux_arbiter2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Burst counter width; an unlimited burst still keeps a 1-bit free-running counter.
    function automatic int unsigned cnt_width(input int unsigned max_burst);
        return (max_burst == 0) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux_arbiter2_pick.sv
// Next-owner decision: tie-break on ptr from IDLE, hand over on burst limit or request drop.
module mux_arbiter2_pick
    import mux_arbiter2_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  logic   ptr,
    input  state_e state,
    input  logic   limit_hit,
    output state_e next_state,
    output logic   take_other
);

    always_comb begin
        next_state = state;
        take_other = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = (ptr == REQ1) ? OWN1 : OWN0;
                end else if (req0) begin
                    next_state = OWN0;
                end else if (req1) begin
                    next_state = OWN1;
                end
            end
            OWN0: begin
                if (req0) begin
                    if (limit_hit && req1) begin
                        next_state = OWN1;
                        take_other = 1'b1;
                    end
                end else if (req1) begin
                    next_state = OWN1;
                    take_other = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (limit_hit && req0) begin
                        next_state = OWN0;
                        take_other = 1'b1;
                    end
                end else if (req0) begin
                    next_state = OWN0;
                    take_other = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/mux_arbiter2.sv
// Round-robin arbiter owning a shared 2:1 datapath mux, with a registered output stage.
module mux_arbiter2
    import mux_arbiter2_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             src
);

    localparam int unsigned CntW = cnt_width(MAX_BURST);

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q;
    logic              dout_valid_q;
    logic              src_q;

    logic              xfer;
    logic              burst_end;
    logic              limit_hit;
    logic              take_other;
    logic              enter;
    logic [WIDTH-1:0]  mux_out;

    assign xfer      = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);
    assign burst_end = (MAX_BURST != 0) && ((32'(cnt_q) + 32'd1) == MAX_BURST);
    assign limit_hit = xfer && burst_end;
    assign mux_out   = sel ? din1 : din0;

    mux_arbiter2_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .ptr        (ptr_q),
        .state      (state_q),
        .limit_hit  (limit_hit),
        .next_state (state_d),
        .take_other (take_other)
    );

    // Any move into an OWN state, whether from IDLE or a direct handover.
    assign enter = take_other || ((state_q == IDLE) && (state_d != IDLE));

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (enter) begin
            ptr_d = (state_d == OWN0) ? REQ1 : REQ0;
            cnt_d = '0;
        end else if (limit_hit) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= REQ0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            src_q        <= REQ0;
        end else begin
            dout_valid_q <= xfer;
            if (xfer) begin
                dout_q <= mux_out;
                src_q  <= sel;
            end
        end
    end

    always_comb begin
        gnt0       = (state_q == OWN0);
        gnt1       = (state_q == OWN1);
        sel        = (state_q == OWN1);
        dout       = dout_q;
        dout_valid = dout_valid_q;
        src        = src_q;
    end

    a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1))
        else $error("gnt0 and gnt1 asserted together");

endmodule

// File: tb/tb_mux_arbiter2.sv
// Bench for mux_arbiter2: directed scenarios with literal expectations plus a random run
// checked every cycle against an ownership/burst-count model of the arbiter.
module tb_mux_arbiter2;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] din0, din1;
    logic             gnt0, gnt1, sel, dout_valid, src;
    logic [WIDTH-1:0] dout;

    int errors = 0;
    int checks = 0;

    // Model: current owner (-1 = nobody), who wins a tie, transfers since taking ownership.
    int               owner;
    bit               favour;
    int               run;
    logic [WIDTH-1:0] m_dout;
    bit               m_valid;
    bit               m_src;

    always #5 clk = ~clk;

    mux_arbiter2 #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .din0       (din0),
        .din1       (din1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .src        (src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner   = -1;
        favour  = 1'b0;
        run     = 0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_src   = 1'b0;
    endtask

    task automatic model_take(input int x);
        owner  = x;
        favour = (x == 0);
        run    = 0;
    endtask

    task automatic model_advance();
        bit               r[2];
        logic [WIDTH-1:0] d[2];
        int               o;
        r[0] = req0;
        r[1] = req1;
        d[0] = din0;
        d[1] = din1;
        m_valid = 1'b0;
        if (owner < 0) begin
            if (r[0] && r[1]) model_take(favour ? 1 : 0);
            else if (r[0])    model_take(0);
            else if (r[1])    model_take(1);
        end else begin
            o = owner;
            if (r[o]) begin
                m_valid = 1'b1;
                m_dout  = d[o];
                m_src   = (o == 1);
                run++;
                if (MAX_BURST != 0 && (run % int'(MAX_BURST)) == 0 && r[1-o]) model_take(1 - o);
            end else if (r[1-o]) begin
                model_take(1 - o);
            end else begin
                owner = -1;
            end
        end
    endtask

    task automatic check_model();
        if (rst) model_reset();
        chk("model gnt0", gnt0, owner == 0);
        chk("model gnt1", gnt1, owner == 1);
        chk("model sel", sel, owner == 1);
        chk("model dout", dout, m_dout);
        chk("model dout_valid", dout_valid, m_valid);
        chk("model src", src, m_src);
        if (!rst) model_advance();
    endtask

    // Compare at the falling edge, then return 1 unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int valid_cnt;
        model_reset();

        // Reset holds everything at zero regardless of inputs.
        rst  = 1'b1;
        req0 = 1'($urandom_range(0, 1));
        req1 = 1'($urandom_range(0, 1));
        din0 = 8'($urandom);
        din1 = 8'($urandom);
        step();
        step();
        chk("rst gnt0", gnt0, 0);
        chk("rst gnt1", gnt1, 0);
        chk("rst sel", sel, 0);
        chk("rst dout", dout, 0);
        chk("rst dout_valid", dout_valid, 0);
        chk("rst src", src, 0);
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle gnt0", gnt0, 0);
            chk("idle gnt1", gnt1, 0);
            chk("idle dout_valid", dout_valid, 0);
        end

        // Single requester: grant one cycle after req, data one cycle after grant.
        req0 = 1'b1;
        din0 = 8'hA5;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("solo gnt0", gnt0, (k >= 1 && k <= 4));
            chk("solo gnt1", gnt1, 0);
            chk("solo dout_valid", dout_valid, (k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) begin
                chk("solo dout", dout, 8'hA5);
                chk("solo src", src, 0);
            end
            if (k == 4) req0 = 1'b0;
        end

        // Both requesting: bursts of MAX_BURST alternate with no bubble.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        din0 = 8'h11;
        din1 = 8'h22;
        for (int k = 1; k <= 16; k++) begin
            bit own0;
            bit word0;
            step();
            own0 = (((k - 1) / 4) % 2) == 0;
            chk("alt gnt0", gnt0, own0);
            chk("alt gnt1", gnt1, !own0);
            chk("alt dout_valid", dout_valid, k >= 2);
            if (k >= 2) begin
                word0 = (((k - 2) / 4) % 2) == 0;
                chk("alt dout", dout, word0 ? 8'h11 : 8'h22);
                chk("alt src", src, !word0);
            end
        end

        // Owner drops request while the other waits: one empty cycle, then handover.
        do_reset();
        req0 = 1'b1;
        din0 = 8'h33;
        din1 = 8'h22;
        step();
        step();
        chk("drop pre dout", dout, 8'h33);
        req0 = 1'b0;
        req1 = 1'b1;
        step();
        chk("drop gap dout_valid", dout_valid, 0);
        chk("drop gnt1", gnt1, 1);
        chk("drop gnt0", gnt0, 0);
        step();
        chk("drop dout_valid", dout_valid, 1);
        chk("drop dout", dout, 8'h22);
        chk("drop src", src, 1);

        // Asynchronous reset pulse mid-burst clears outputs before any clock edge.
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        din0 = 8'h11;
        din1 = 8'h22;
        step();
        step();
        step();
        #1 rst = 1'b1;
        #1;
        chk("async gnt0", gnt0, 0);
        chk("async gnt1", gnt1, 0);
        chk("async dout_valid", dout_valid, 0);
        chk("async dout", dout, 0);
        rst = 1'b0;
        model_reset();
        step();
        chk("after async gnt0", gnt0, 1);
        chk("after async gnt1", gnt1, 0);

        // Lone requester streams through the burst-limit wrap without gaps.
        do_reset();
        req0 = 1'b1;
        din0 = 8'h40;
        valid_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (dout_valid) valid_cnt++;
            chk("stream gnt0", gnt0, (k <= 11));
            chk("stream dout_valid", dout_valid, (k >= 2 && k <= 11));
            if (k >= 2 && k <= 11) chk("stream dout", dout, 8'h40 + k - 1);
            din0 = 8'(8'h40 + k);
            if (k == 11) req0 = 1'b0;
        end
        chk("stream word count", valid_cnt, 10);

        // Random traffic with occasional synchronous and mid-cycle resets.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            int dens;
            dens = (k / 500) % 4;
            req0 = ($urandom_range(0, 99) < 30 + 20 * dens);
            req1 = ($urandom_range(0, 99) < 90 - 20 * dens);
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
            end
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
